// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected stream engine: FSM encoding,
// derived widths and saturation limits.
package fc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } fc_state_t;

  function automatic int num_words(input int out_ch, input int act_per_addr);
    return (out_ch + act_per_addr - 1) / act_per_addr;
  endfunction

  // Product width plus headroom for IN_LEN products and the shifted bias.
  function automatic int acc_bw(input int bw_act, input int bw_param, input int in_len);
    return bw_act + bw_param + $clog2(in_len) + 2;
  endfunction

  function automatic int sat_max(input int bw);
    return (1 << (bw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int bw);
    return -(1 << (bw - 1));
  endfunction

endpackage

// File: rtl/fc_requant.sv
// Per-channel requantisation: round-half-up shift, saturate to the activation
// range, optional ReLU clamp.
module fc_requant
  import fc_pkg::*;
#(
  parameter int ACC_BW     = 28,
  parameter int BW_OUT     = 12,
  parameter int FRAC_SHIFT = 7
) (
  input  logic signed [ACC_BW-1:0] acc,
  input  logic                     relu,
  output logic signed [BW_OUT-1:0] q
);

  localparam int EW = ACC_BW + 1;
  localparam logic signed [EW-1:0] RND = EW'(1) <<< (FRAC_SHIFT - 1);
  localparam logic signed [EW-1:0] HI  = EW'(sat_max(BW_OUT));
  localparam logic signed [EW-1:0] LO  = EW'(sat_min(BW_OUT));

  logic signed [EW-1:0] rounded;
  logic signed [EW-1:0] shifted;

  // One extra bit keeps the rounding add from wrapping at the top of the range.
  always_comb begin
    rounded = {acc[ACC_BW-1], acc} + RND;
    shifted = rounded >>> FRAC_SHIFT;
    if (shifted > HI) begin
      q = HI[BW_OUT-1:0];
    end else if (shifted < LO) begin
      q = LO[BW_OUT-1:0];
    end else begin
      q = shifted[BW_OUT-1:0];
    end
    if (relu && q[BW_OUT-1]) begin
      q = '0;
    end
  end

endmodule

// File: rtl/fc_stream_engine.sv
// Streaming fully-connected layer: accumulates IN_LEN activation beats into
// OUT_CH neurons, then emits requantised results as packed words.
module fc_stream_engine
  import fc_pkg::*;
#(
  parameter int OUT_CH       = 6,
  parameter int IN_LEN       = 64,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 12,
  parameter int BW_PER_PARAM = 8,
  parameter int BIAS_SHIFT   = 8,
  parameter int FRAC_SHIFT   = 7
) (
  input  logic                                       clk,
  input  logic                                       srst_n,
  input  logic                                       start,
  input  logic                                       relu_en,
  input  logic [OUT_CH*BW_PER_PARAM-1:0]             bias,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic signed [BW_PER_ACT-1:0]               f0,
  input  logic [OUT_CH*BW_PER_PARAM-1:0]             weight,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [ACT_PER_ADDR*BW_PER_ACT-1:0]         sram_wdata,
  output logic [$clog2(num_words(OUT_CH, ACT_PER_ADDR)):0] word_idx,
  output logic                                       busy,
  output logic                                       done,
  output logic [$clog2(IN_LEN):0]                    in_count
);

  localparam int NUM_WORDS = num_words(OUT_CH, ACT_PER_ADDR);
  localparam int ACC_BW    = acc_bw(BW_PER_ACT, BW_PER_PARAM, IN_LEN);
  localparam int PROD_W    = BW_PER_ACT + BW_PER_PARAM;
  localparam int WI_W      = $clog2(NUM_WORDS) + 1;
  localparam int IC_W      = $clog2(IN_LEN) + 1;
  localparam int LANES     = NUM_WORDS * ACT_PER_ADDR;
  localparam int WORD_W    = ACT_PER_ADDR * BW_PER_ACT;

  fc_state_t                state_reg;
  logic                     in_ready_reg;
  logic                     out_valid_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic                     relu_reg;
  logic [IC_W-1:0]          in_count_reg;
  logic [WI_W-1:0]          word_idx_reg;
  logic                     start_fire;
  logic                     beat_fire;
  logic signed [BW_PER_ACT-1:0] q_lane [LANES];
  logic [WORD_W-1:0]        word_data [NUM_WORDS];

  assign start_fire = (state_reg == ST_IDLE) && start;
  assign beat_fire  = (state_reg == ST_ACC) && in_valid;

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_reg     <= ST_IDLE;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      relu_reg      <= 1'b0;
      in_count_reg  <= '0;
      word_idx_reg  <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_ACC;
            in_ready_reg <= 1'b1;
            busy_reg     <= 1'b1;
            relu_reg     <= relu_en;
            in_count_reg <= '0;
          end
        end
        ST_ACC: begin
          if (in_valid) begin
            in_count_reg <= in_count_reg + IC_W'(1);
            if (in_count_reg == IC_W'(IN_LEN - 1)) begin
              state_reg     <= ST_OUT;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              word_idx_reg  <= '0;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            if (word_idx_reg == WI_W'(NUM_WORDS - 1)) begin
              state_reg     <= ST_IDLE;
              out_valid_reg <= 1'b0;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              word_idx_reg  <= '0;
            end else begin
              word_idx_reg <= word_idx_reg + WI_W'(1);
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < OUT_CH; gi++) begin : g_ch
      logic [BW_PER_PARAM-1:0]  w_c;
      logic [BW_PER_PARAM-1:0]  b_c;
      logic [PROD_W-1:0]        prod;
      logic signed [ACC_BW-1:0] acc_reg;

      assign w_c = weight[(OUT_CH-1-gi)*BW_PER_PARAM +: BW_PER_PARAM];
      assign b_c = bias[(OUT_CH-1-gi)*BW_PER_PARAM +: BW_PER_PARAM];
      // Both operands sign-extended to the full product width, so the low
      // PROD_W bits of the unsigned multiply are the exact signed product.
      assign prod = {{BW_PER_PARAM{f0[BW_PER_ACT-1]}}, f0}
                  * {{BW_PER_ACT{w_c[BW_PER_PARAM-1]}}, w_c};

      always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
          acc_reg <= '0;
        end else if (start_fire) begin
          acc_reg <= {{(ACC_BW-BW_PER_PARAM){b_c[BW_PER_PARAM-1]}}, b_c} << BIAS_SHIFT;
        end else if (beat_fire) begin
          acc_reg <= acc_reg + {{(ACC_BW-PROD_W){prod[PROD_W-1]}}, prod};
        end
      end

      fc_requant #(
        .ACC_BW    (ACC_BW),
        .BW_OUT    (BW_PER_ACT),
        .FRAC_SHIFT(FRAC_SHIFT)
      ) u_requant (
        .acc (acc_reg),
        .relu(relu_reg),
        .q   (q_lane[gi])
      );
    end

    for (gi = OUT_CH; gi < LANES; gi++) begin : g_pad
      assign q_lane[gi] = '0;
    end

    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      for (gj = 0; gj < ACT_PER_ADDR; gj++) begin : g_lane
        assign word_data[gi][(ACT_PER_ADDR-1-gj)*BW_PER_ACT +: BW_PER_ACT] =
          q_lane[gi*ACT_PER_ADDR + gj];
      end
    end
  endgenerate

  always_comb begin
    sram_wdata = '0;
    if (out_valid_reg) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (word_idx_reg == WI_W'(k)) begin
          sram_wdata = word_data[k];
        end
      end
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign word_idx  = word_idx_reg;
  assign in_count  = in_count_reg;

endmodule

// File: tb/tb_fc_stream_engine.sv
// Scoreboard bench for fc_stream_engine: directed and random runs checked
// against an arithmetic reference model.
module tb_fc_stream_engine;

  localparam int OUT_CH = 6;
  localparam int IN_LEN = 4;
  localparam int APA    = 4;
  localparam int BWA    = 12;
  localparam int BWP    = 8;
  localparam int NW     = 2;
  localparam int DW     = APA * BWA;
  localparam int WI_W   = 2;
  localparam int IC_W   = 3;

  logic clk = 1'b0;
  logic srst_n = 1'b1;
  logic start = 1'b0;
  logic relu_en = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [OUT_CH*BWP-1:0] bias = '0;
  logic [OUT_CH*BWP-1:0] weight = '0;
  logic signed [BWA-1:0] f0 = '0;
  logic in_ready, out_valid, busy, done;
  logic [DW-1:0] sram_wdata;
  logic [WI_W-1:0] word_idx;
  logic [IC_W-1:0] in_count;

  always #5 clk = ~clk;

  fc_stream_engine #(
    .OUT_CH(OUT_CH), .IN_LEN(IN_LEN), .ACT_PER_ADDR(APA),
    .BW_PER_ACT(BWA), .BW_PER_PARAM(BWP), .BIAS_SHIFT(8), .FRAC_SHIFT(7)
  ) dut (
    .clk(clk), .srst_n(srst_n), .start(start), .relu_en(relu_en),
    .bias(bias), .in_valid(in_valid), .in_ready(in_ready), .f0(f0),
    .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
    .sram_wdata(sram_wdata), .word_idx(word_idx), .busy(busy),
    .done(done), .in_count(in_count)
  );

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [WI_W-1:0] idx;
    logic            last;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   done_exp = 1'b0;
  int   cur_bias[OUT_CH];
  int   cur_f0[IN_LEN];
  int   cur_w[IN_LEN][OUT_CH];
  bit   cur_relu;

  task automatic check(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: exact integer dot product, round half up, clamp, ReLU, pack.
  function automatic void push_expected();
    int   qv[OUT_CH];
    exp_t e;
    for (int c = 0; c < OUT_CH; c++) begin
      longint acc;
      longint q;
      acc = longint'(cur_bias[c]) * 256;
      for (int b = 0; b < IN_LEN; b++) acc += longint'(cur_f0[b]) * longint'(cur_w[b][c]);
      q = (acc + 64) >>> 7;
      if (q > 2047) q = 2047;
      if (q < -2048) q = -2048;
      if (cur_relu && q < 0) q = 0;
      qv[c] = int'(q);
    end
    for (int k = 0; k < NW; k++) begin
      e = '0;
      for (int l = 0; l < APA; l++) begin
        int ch;
        int v;
        ch = k * APA + l;
        v  = (ch < OUT_CH) ? qv[ch] : 0;
        e.data[(APA-1-l)*BWA +: BWA] = v[BWA-1:0];
      end
      e.idx  = k[WI_W-1:0];
      e.last = (k == NW - 1);
      exp_q.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (srst_n) begin
      if (done_exp) begin
        check("done_pulse", done, 1);
        done_exp = 1'b0;
      end else begin
        check("done_idle", done, 0);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", out_valid, 0);
        end else begin
          check("word_data", sram_wdata, exp_q[0].data);
          check("word_idx", word_idx, exp_q[0].idx);
          if (out_ready) begin
            done_exp = exp_q[0].last;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("wdata_zero", sram_wdata, 0);
      end
    end
  end

  task automatic set_uniform(input int b0, input int fv, input int wv, input bit relu);
    for (int c = 0; c < OUT_CH; c++) cur_bias[c] = (c == 0) ? b0 : 0;
    for (int b = 0; b < IN_LEN; b++) begin
      cur_f0[b] = fv;
      for (int c = 0; c < OUT_CH; c++) cur_w[b][c] = wv;
    end
    cur_relu = relu;
  endtask

  task automatic set_random();
    for (int c = 0; c < OUT_CH; c++) cur_bias[c] = int'($urandom_range(0, 255)) - 128;
    for (int b = 0; b < IN_LEN; b++) begin
      cur_f0[b] = int'($urandom_range(0, 4095)) - 2048;
      for (int c = 0; c < OUT_CH; c++) cur_w[b][c] = int'($urandom_range(0, 255)) - 128;
    end
    cur_relu = $urandom_range(0, 1) == 1;
  endtask

  task automatic do_run(input bit gaps, input bit stall0, input bit start_mid, input bit reset_mid);
    int acc_n = 0;
    int guard = 0;
    int cyc = 0;
    bit rdy;
    bit mid_done = 1'b0;
    for (int c = 0; c < OUT_CH; c++) begin
      int t;
      t = cur_bias[c];
      bias[(OUT_CH-1-c)*BWP +: BWP] = t[BWP-1:0];
    end
    relu_en = cur_relu;
    start = 1'b1;
    push_expected();
    @(posedge clk); #1;
    start = 1'b0;
    relu_en = ~cur_relu;
    for (int c = 0; c < OUT_CH; c++) bias[(OUT_CH-1-c)*BWP +: BWP] = 8'($urandom);
    while (acc_n < IN_LEN && guard < 200) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        f0 = 12'(cur_f0[acc_n]);
        for (int c = 0; c < OUT_CH; c++) begin
          int t;
          t = cur_w[acc_n][c];
          weight[(OUT_CH-1-c)*BWP +: BWP] = t[BWP-1:0];
        end
      end
      if (start_mid && acc_n == 1 && !mid_done) begin
        start = 1'b1;
        mid_done = 1'b1;
      end
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (in_valid && rdy) acc_n++;
      guard++;
      if (reset_mid && acc_n == 2) begin
        in_valid = 1'b0;
        #2 srst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wdata", sram_wdata, 0);
        check("rst_in_count", in_count, 0);
        check("rst_word_idx", word_idx, 0);
        exp_q.delete();
        @(posedge clk); #1;
        srst_n = 1'b1;
        return;
      end
    end
    in_valid = 1'b0;
    check("beat_timeout", acc_n, IN_LEN);
    check("in_count_full", in_count, IN_LEN);
    check("out_valid_after_last", out_valid, 1);
    while (busy && cyc < 200) begin
      out_ready = (stall0 && cyc < 5) ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_timeout", busy, 0);
  endtask

  initial begin
    #2 srst_n = 1'b0;
    #1;
    check("reset_in_ready", in_ready, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wdata", sram_wdata, 0);
    check("reset_in_count", in_count, 0);
    check("reset_word_idx", word_idx, 0);
    repeat (2) @(posedge clk);
    #1 srst_n = 1'b1;
    @(posedge clk); #1;

    set_uniform(0, 128, 1, 1'b0);     do_run(0, 0, 0, 0);
    set_uniform(1, 128, 1, 1'b0);     do_run(0, 0, 0, 0);
    set_uniform(0, 2047, 127, 1'b0);  do_run(0, 0, 0, 0);
    set_uniform(0, -2048, 127, 1'b0); do_run(0, 0, 0, 0);
    set_uniform(0, -2048, 127, 1'b1); do_run(0, 0, 0, 0);

    // Channel sums 64, -64, -65, 0, 63, -63 exercise the rounding boundaries.
    set_uniform(0, 16, 0, 1'b0);
    cur_f0[3] = 1;
    for (int b = 0; b < 3; b++) begin
      cur_w[b][0] = 1;  cur_w[b][1] = -1; cur_w[b][2] = -1;
      cur_w[b][4] = 1;  cur_w[b][5] = -1;
    end
    cur_w[3][0] = 16; cur_w[3][1] = -16; cur_w[3][2] = -17;
    cur_w[3][4] = 15; cur_w[3][5] = -15;
    do_run(0, 0, 0, 0);

    set_random(); do_run(1, 1, 1, 0);
    set_random(); do_run(1, 0, 1, 0);
    set_random(); do_run(1, 1, 0, 1);
    set_random(); do_run(1, 0, 0, 0);
    for (int r = 0; r < 6; r++) begin
      set_random();
      do_run(1, r[0], r[1], 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fc_stream_engine.md
FC_STREAM_ENGINE -- requirements
Module: fc_stream_engine

Interface
REQ-001 SHALL have parameter OUT_CH, default 6, meaning number of output channels (neurons).
REQ-002 SHALL have parameter IN_LEN, default 64, meaning input activations accumulated per run.
REQ-003 SHALL have parameter ACT_PER_ADDR, default 4, meaning activations packed per output word.
REQ-004 SHALL have parameter BW_PER_ACT, default 12, meaning activation bit width (signed).
REQ-005 SHALL have parameter BW_PER_PARAM, default 8, meaning weight/bias bit width (signed).
REQ-006 SHALL have parameters BIAS_SHIFT, default 8, and FRAC_SHIFT, default 7, meaning bias alignment shift and output requantisation shift.
REQ-007 SHALL have ports: clk  in  1  clock; srst_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have ports: start  in  1  run-start pulse; relu_en  in  1  clamp negatives to 0, sampled at start.
REQ-009 SHALL have ports: bias  in  OUT_CH*BW_PER_PARAM  per-channel bias, channel 0 in MSBs, sampled at start.
REQ-010 SHALL have ports: in_valid  in  1; in_ready  out  1; f0  in  BW_PER_ACT  signed activation; weight  in  OUT_CH*BW_PER_PARAM  per-channel weights for this beat, channel 0 in MSBs.
REQ-011 SHALL have ports: out_valid  out  1; out_ready  in  1; sram_wdata  out  ACT_PER_ADDR*BW_PER_ACT  packed result word; word_idx  out  clog2(NUM_WORDS)+1  index of current word.
REQ-012 SHALL have ports: busy  out  1  run in progress; done  out  1  one-cycle run-complete pulse; in_count  out  clog2(IN_LEN)+1  beats accepted.

Function
REQ-013 SHALL implement FSM IDLE -> ACC (on start) -> OUT (after beat IN_LEN accepted) -> IDLE (after last word accepted, done pulsed).
REQ-014 SHALL, on start in IDLE, load acc[c] = sign-extended bias[c] << BIAS_SHIFT for every c, clear in_count, latch relu_en.
REQ-015 SHALL ignore start while busy.
REQ-016 SHALL drive in_ready high only in ACC; a beat is accepted when in_valid && in_ready; acc[c] += f0*weight[c] for all c in the same cycle.
REQ-017 SHALL hold accumulators and in_count unchanged on cycles with no accepted beat (gaps are legal).
REQ-018 SHALL size accumulators ACC_BW = BW_PER_ACT+BW_PER_PARAM+clog2(IN_LEN)+2, signed, with no internal overflow for any legal input.
REQ-019 SHALL compute per channel q = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT (arithmetic), then saturate to [-2^(BW_PER_ACT-1), 2^(BW_PER_ACT-1)-1], then if latched relu_en force negatives to 0.
REQ-020 SHALL output NUM_WORDS = ceil(OUT_CH/ACT_PER_ADDR) words; word k holds channels k*ACT_PER_ADDR.. in MSB-first lane order; unused lanes of the last word are zero.
REQ-021 SHALL assert out_valid the cycle after the final beat is accepted (FSM in OUT), word_idx starting at 0.
REQ-022 SHALL hold sram_wdata and word_idx stable while out_valid && !out_ready; advance word_idx on out_valid && out_ready.
REQ-023 SHALL, on acceptance of word NUM_WORDS-1, pulse done for exactly one cycle, deassert out_valid and busy, return to IDLE.
REQ-024 SHALL accept a start in the cycle immediately after done (back-to-back runs, no bubble required beyond that).
REQ-025 SHALL drive sram_wdata to zero whenever out_valid is low.

Reset
REQ-026 SHALL, on srst_n low, asynchronously force IDLE, accumulators 0, in_count 0, word_idx 0, in_ready/out_valid/busy/done 0, sram_wdata 0.
REQ-027 SHALL abandon any run on reset mid-ACC or mid-OUT with no further output, and require a new start afterwards.

Structure
REQ-028 SHALL place FSM state encoding, NUM_WORDS/ACC_BW derivation functions and saturation limits in shared package fc_pkg.
REQ-029 SHALL implement round/saturate/ReLU as one sub-module fc_requant, instantiated OUT_CH times via generate.

Verification
REQ-030 SHALL cover: OUT_CH=6, IN_LEN=4, bias 0, f0=128, all w=1 -> two words, word0 lanes all 4, word1 {4,4,0,0}, done after word1.
REQ-031 SHALL cover: same with bias[0]=1 -> ch0 acc=768 -> 6; ch1..5 -> 4.
REQ-032 SHALL cover: f0=2047, w=127 x4 -> 2047; f0=-2048, w=127 x4 -> -2048; with relu_en=1 the latter -> 0.
REQ-033 SHALL cover rounding: final acc 64 -> 1, acc -64 -> 0, acc -65 -> -1.
REQ-034 SHALL cover: random in_valid gaps and out_ready held low 5 cycles on word0 -> results identical, sram_wdata stable while stalled, start during busy ignored.
REQ-035 SHALL cover: srst_n asserted after beat 2 -> all outputs 0 immediately; new start then yields correct fresh results.
